// File: rtl/dcpu_bus_arb_if.sv
// -----------------------------------------------------------------------------
// dcpu_bus_arb_if
// Bus bundle for the two-master / one-slave dcpu memory arbiter.
//   m0_* / m1_* : requester side (addr, write data, we, cs in; read data,
//                 ack, err out)
//   s_*         : shared slave side (addr, write data, we, cs out; read
//                 data, ack in)
//   o_owner     : current or last granted master
//   o_busy      : arbiter is holding a multi-cycle transfer
// Modports:
//   slave  : the arbiter's view (it serves the two masters)
//   master : the environment's view (requesters plus the memory/decode side)
// -----------------------------------------------------------------------------
interface dcpu_bus_arb_if #(
   parameter int AW = 16,
   parameter int DW = 16
) ();
   logic [AW-1:0] i_m0_addr;
   logic [DW-1:0] i_m0_dat;
   logic          i_m0_we;
   logic          i_m0_cs;
   logic [DW-1:0] o_m0_dat;
   logic          o_m0_ack;
   logic          o_m0_err;

   logic [AW-1:0] i_m1_addr;
   logic [DW-1:0] i_m1_dat;
   logic          i_m1_we;
   logic          i_m1_cs;
   logic [DW-1:0] o_m1_dat;
   logic          o_m1_ack;
   logic          o_m1_err;

   logic [AW-1:0] o_s_addr;
   logic [DW-1:0] o_s_dat;
   logic          o_s_we;
   logic          o_s_cs;
   logic [DW-1:0] i_s_dat;
   logic          i_s_ack;

   logic          o_owner;
   logic          o_busy;

   modport slave (
      input  i_m0_addr, i_m0_dat, i_m0_we, i_m0_cs,
      output o_m0_dat, o_m0_ack, o_m0_err,
      input  i_m1_addr, i_m1_dat, i_m1_we, i_m1_cs,
      output o_m1_dat, o_m1_ack, o_m1_err,
      output o_s_addr, o_s_dat, o_s_we, o_s_cs,
      input  i_s_dat, i_s_ack,
      output o_owner, o_busy
   );

   modport master (
      output i_m0_addr, i_m0_dat, i_m0_we, i_m0_cs,
      input  o_m0_dat, o_m0_ack, o_m0_err,
      output i_m1_addr, i_m1_dat, i_m1_we, i_m1_cs,
      input  o_m1_dat, o_m1_ack, o_m1_err,
      input  o_s_addr, o_s_dat, o_s_we, o_s_cs,
      output i_s_dat, i_s_ack,
      input  o_owner, o_busy
   );
endinterface

// File: rtl/dcpu_bus_arb.sv
// -----------------------------------------------------------------------------
// dcpu_bus_arb
// Round-robin arbiter placing the dcpu core (master 0) and a second requester
// (master 1) onto one memory/peripheral slave port. Grants are formed
// combinationally in IDLE so a slave that acks immediately completes in one
// cycle; otherwise the winner holds the bus in BUSY until ack, abort (cs
// dropped) or watchdog timeout, which returns ERR_DATA with err set.
// Ports:
//   i_clk      : clock, rising edge
//   i_reset_n  : asynchronous active-low reset; release is expected to be
//                synchronous to i_clk
//   bus        : dcpu_bus_arb_if.slave - master request/response pairs,
//                slave port, owner and busy status
// -----------------------------------------------------------------------------
module dcpu_bus_arb #(
   parameter int              AW       = 16,
   parameter int              DW       = 16,
   parameter int              TIMEOUT  = 255,
   parameter int              TW       = 8,
   parameter logic [DW-1:0]   ERR_DATA = 16'hFFFF
) (
   input  logic           i_clk,
   input  logic           i_reset_n,
   dcpu_bus_arb_if.slave  bus
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Watchdog value at which a BUSY transfer is forcibly terminated.
   localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

   state_t        state_r, state_nxt_s;
   logic          prio_r, prio_nxt_s;
   logic          owner_r, owner_nxt_s;
   logic [TW-1:0] wd_r, wd_nxt_s;

   logic          req0_s, req1_s, owner_cs_s;
   logic          grant_s;      // a master currently drives the slave port
   logic          grant_id_s;   // which master is (or was) being served
   logic          ack_s;        // normal completion this cycle
   logic          timeout_s;    // watchdog completion this cycle

   // Requests are masked while reset is held so the combinational grant path
   // cannot drive the slave port or any ack during reset.
   always_comb begin
      req0_s     = bus.i_m0_cs & i_reset_n;
      req1_s     = bus.i_m1_cs & i_reset_n;
      owner_cs_s = owner_r ? req1_s : req0_s;
   end

   // Next-state, grant and completion decode.
   always_comb begin
      state_nxt_s = state_r;
      prio_nxt_s  = prio_r;
      owner_nxt_s = owner_r;
      wd_nxt_s    = wd_r;
      grant_s     = 1'b0;
      grant_id_s  = 1'b0;
      ack_s       = 1'b0;
      timeout_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req0_s && req1_s) begin
               grant_s    = 1'b1;
               grant_id_s = prio_r;
            end else if (req0_s) begin
               grant_s    = 1'b1;
               grant_id_s = 1'b0;
            end else if (req1_s) begin
               grant_s    = 1'b1;
               grant_id_s = 1'b1;
            end else begin
               grant_s    = 1'b0;
               grant_id_s = 1'b0;
            end
            if (grant_s) begin
               owner_nxt_s = grant_id_s;
               if (bus.i_s_ack) begin
                  // single-cycle transfer, stay in IDLE
                  ack_s      = 1'b1;
                  prio_nxt_s = ~grant_id_s;
               end else begin
                  state_nxt_s = ST_BUSY;
                  wd_nxt_s    = {TW{1'b0}};
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            grant_id_s = owner_r;
            if (!owner_cs_s) begin
               // abort: owner withdrew, nobody is acked, priority untouched
               state_nxt_s = ST_IDLE;
            end else if (bus.i_s_ack) begin
               grant_s     = 1'b1;
               ack_s       = 1'b1;
               prio_nxt_s  = ~owner_r;
               state_nxt_s = ST_IDLE;
            end else if (wd_r == WD_LAST) begin
               // slave deselected during the error cycle
               timeout_s   = 1'b1;
               prio_nxt_s  = ~owner_r;
               state_nxt_s = ST_IDLE;
            end else begin
               grant_s  = 1'b1;
               wd_nxt_s = wd_r + TW'(1);
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State, round-robin pointer, owner and watchdog registers.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_r <= ST_IDLE;
         prio_r  <= 1'b0;
         owner_r <= 1'b0;
         wd_r    <= {TW{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         prio_r  <= prio_nxt_s;
         owner_r <= owner_nxt_s;
         wd_r    <= wd_nxt_s;
      end
   end

   // Slave port mux: only the granted master is visible, else all zero.
   always_comb begin
      bus.o_s_addr = {AW{1'b0}};
      bus.o_s_dat  = {DW{1'b0}};
      bus.o_s_we   = 1'b0;
      bus.o_s_cs   = 1'b0;
      if (grant_s) begin
         bus.o_s_cs = 1'b1;
         if (grant_id_s) begin
            bus.o_s_addr = bus.i_m1_addr;
            bus.o_s_dat  = bus.i_m1_dat;
            bus.o_s_we   = bus.i_m1_we;
         end else begin
            bus.o_s_addr = bus.i_m0_addr;
            bus.o_s_dat  = bus.i_m0_dat;
            bus.o_s_we   = bus.i_m0_we;
         end
      end else begin
         bus.o_s_cs = 1'b0;
      end
   end

   // Response routing: ack/err/data reach only the master being served.
   always_comb begin
      bus.o_m0_ack = (ack_s | timeout_s) & ~grant_id_s;
      bus.o_m1_ack = (ack_s | timeout_s) &  grant_id_s;
      bus.o_m0_err = timeout_s & ~grant_id_s;
      bus.o_m1_err = timeout_s &  grant_id_s;
      bus.o_m0_dat = {DW{1'b0}};
      bus.o_m1_dat = {DW{1'b0}};
      if (timeout_s) begin
         if (grant_id_s) begin
            bus.o_m1_dat = ERR_DATA;
         end else begin
            bus.o_m0_dat = ERR_DATA;
         end
      end else if (grant_s) begin
         if (grant_id_s) begin
            bus.o_m1_dat = bus.i_s_dat;
         end else begin
            bus.o_m0_dat = bus.i_s_dat;
         end
      end else begin
         bus.o_m0_dat = {DW{1'b0}};
      end
   end

   // Status outputs come straight from registers.
   always_comb begin
      bus.o_owner = owner_r;
      bus.o_busy  = (state_r == ST_BUSY);
   end

endmodule

// File: tb/tb_dcpu_bus_arb.sv
// -----------------------------------------------------------------------------
// tb_dcpu_bus_arb
// Directed scenarios followed by randomized traffic, every cycle compared
// against a transaction-level reference model of the arbitration rules.
// Inputs change on the falling edge; outputs are compared 2 ns later.
// -----------------------------------------------------------------------------
module tb_dcpu_bus_arb;
   localparam int AW = 16;
   localparam int DW = 16;
   localparam int TO = 4;
   localparam int TW = 8;

   logic i_clk     = 1'b0;
   logic i_reset_n = 1'b0;

   dcpu_bus_arb_if #(.AW(AW), .DW(DW)) bus ();

   dcpu_bus_arb #(
      .AW(AW), .DW(DW), .TIMEOUT(TO), .TW(TW), .ERR_DATA(16'hFFFF)
   ) dut (
      .i_clk    (i_clk),
      .i_reset_n(i_reset_n),
      .bus      (bus)
   );

   always #5 i_clk = ~i_clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // stimulus state
   logic        cs   [2];
   logic [15:0] addr [2];
   logic [15:0] wdat [2];
   logic        we   [2];
   logic        s_ack;
   logic [15:0] s_dat;
   bit          got_ack [2];

   // reference model: is a transfer outstanding, who holds it, who is
   // preferred next, and when the hold began
   bit m_busy, m_owner, m_prio;
   int m_grant_cyc;
   // per-cycle expectations
   bit e_gv, e_id, e_ack, e_err;

   int order_q[$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic apply();
      bus.i_m0_cs   = cs[0];  bus.i_m0_addr = addr[0];
      bus.i_m0_dat  = wdat[0]; bus.i_m0_we  = we[0];
      bus.i_m1_cs   = cs[1];  bus.i_m1_addr = addr[1];
      bus.i_m1_dat  = wdat[1]; bus.i_m1_we  = we[1];
      bus.i_s_ack   = s_ack;
      bus.i_s_dat   = s_dat;
   endtask

   task automatic model_reset();
      m_busy  = 1'b0;
      m_owner = 1'b0;
      m_prio  = 1'b0;
   endtask

   // What should happen this cycle, from the arbitration rules.
   task automatic model_eval();
      e_gv = 1'b0; e_id = 1'b0; e_ack = 1'b0; e_err = 1'b0;
      if (i_reset_n) begin
         if (!m_busy) begin
            if (cs[0] || cs[1]) begin
               e_gv  = 1'b1;
               e_id  = (cs[0] && cs[1]) ? m_prio : cs[1];
               e_ack = s_ack;
            end
         end else begin
            e_id = m_owner;
            if (cs[m_owner]) begin
               if (s_ack) begin
                  e_gv = 1'b1; e_ack = 1'b1;
               end else if (cyc - m_grant_cyc == TO) begin
                  e_ack = 1'b1; e_err = 1'b1;
               end else begin
                  e_gv = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic model_update();
      if (!i_reset_n) begin
         model_reset();
      end else if (!m_busy) begin
         if (e_gv) begin
            m_owner = e_id;
            if (e_ack) begin
               m_prio = !e_id;
            end else begin
               m_busy      = 1'b1;
               m_grant_cyc = cyc;
            end
         end
      end else if (!e_gv || e_ack) begin
         m_busy = 1'b0;
         if (e_ack) m_prio = !e_id;
      end
   endtask

   task automatic check_outputs();
      logic        a_ack [2];
      logic        a_err [2];
      logic [15:0] a_dat [2];
      logic [15:0] x_dat;
      bit          x_ack;
      a_ack[0] = bus.o_m0_ack; a_ack[1] = bus.o_m1_ack;
      a_err[0] = bus.o_m0_err; a_err[1] = bus.o_m1_err;
      a_dat[0] = bus.o_m0_dat; a_dat[1] = bus.o_m1_dat;
      chk("s_cs", 32'(bus.o_s_cs), 32'(e_gv));
      if (e_gv) begin
         chk("s_addr", 32'(bus.o_s_addr), 32'(addr[e_id]));
         chk("s_dat",  32'(bus.o_s_dat),  32'(wdat[e_id]));
         chk("s_we",   32'(bus.o_s_we),   32'(we[e_id]));
      end
      for (int x = 0; x < 2; x++) begin
         x_ack = e_ack && (int'(e_id) == x);
         if (e_err && int'(e_id) == x)      x_dat = 16'hFFFF;
         else if (e_gv && int'(e_id) == x)  x_dat = s_dat;
         else                               x_dat = 16'h0000;
         chk($sformatf("m%0d_ack", x), 32'(a_ack[x]), 32'(x_ack));
         chk($sformatf("m%0d_err", x), 32'(a_err[x]), 32'(e_err && int'(e_id) == x));
         chk($sformatf("m%0d_dat", x), 32'(a_dat[x]), 32'(x_dat));
         got_ack[x] = x_ack;
         if (a_ack[x] === 1'b1) order_q.push_back(x);
      end
      chk("busy", 32'(bus.o_busy), 32'(m_busy && i_reset_n));
      if (m_busy && i_reset_n) chk("owner", 32'(bus.o_owner), 32'(m_owner));
   endtask

   // One clock: drive (already at negedge), compare, advance the model.
   task automatic step();
      apply();
      #2;
      model_eval();
      check_outputs();
      @(posedge i_clk);
      model_update();
      cyc++;
      @(negedge i_clk);
   endtask

   task automatic randomize_inputs();
      for (int x = 0; x < 2; x++) begin
         if (!cs[x]) begin
            if ($urandom_range(0, 2) == 0) begin
               cs[x]   = 1'b1;
               addr[x] = 16'($urandom);
               wdat[x] = 16'($urandom);
               we[x]   = 1'($urandom);
            end
         end else if (got_ack[x]) begin
            if ($urandom_range(0, 1) == 0) begin
               cs[x] = 1'b0;
            end else begin
               addr[x] = 16'($urandom);
               wdat[x] = 16'($urandom);
               we[x]   = 1'($urandom);
            end
         end else if ($urandom_range(0, 24) == 0) begin
            cs[x] = 1'b0;
         end
      end
      s_ack = ($urandom_range(0, 2) == 0);
      s_dat = 16'($urandom);
   endtask

   initial begin
      for (int x = 0; x < 2; x++) begin
         cs[x] = 1'b0; addr[x] = 16'h0000; wdat[x] = 16'h0000; we[x] = 1'b0;
         got_ack[x] = 1'b0;
      end
      s_ack = 1'b0; s_dat = 16'h0000;
      model_reset();
      m_grant_cyc = 0;
      apply();
      @(negedge i_clk);

      // reset held with both masters requesting: everything stays quiet
      cs[0] = 1'b1; addr[0] = 16'h0100; wdat[0] = 16'h1111;
      cs[1] = 1'b1; addr[1] = 16'h0200; wdat[1] = 16'h2222;
      step();
      step();
      i_reset_n = 1'b1;

      // contention from reset, slave acks on the 3rd cycle of each transfer
      for (int k = 0; k < 12; k++) begin
         s_ack = (k % 3 == 2);
         s_dat = 16'(16'hA000 + k);
         step();
      end
      cs[0] = 1'b0; cs[1] = 1'b0; s_ack = 1'b0;
      step();
      chk("order_n", 32'(order_q.size()), 32'd4);
      for (int i = 0; i < order_q.size() && i < 4; i++)
         chk($sformatf("order%0d", i), 32'(order_q[i]), 32'(i % 2));
      order_q.delete();

      // single-cycle read by m0
      cs[0] = 1'b1; addr[0] = 16'h0010; we[0] = 1'b0; s_ack = 1'b1; s_dat = 16'hBEEF;
      step();
      cs[0] = 1'b0; s_ack = 1'b0;
      step();

      // lock: m0 holds the bus for 5 cycles while m1 waits
      cs[0] = 1'b1; addr[0] = 16'h1234; wdat[0] = 16'h5678; we[0] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (k == 1) begin cs[1] = 1'b1; addr[1] = 16'h4321; we[1] = 1'b0; end
         s_ack = (k == 5);
         s_dat = 16'(16'hC000 + k);
         step();
      end
      cs[0] = 1'b0; s_ack = 1'b1; s_dat = 16'h7777;
      step();
      cs[1] = 1'b0; s_ack = 1'b0;
      step();

      // timeout: m1 write to a slave that never answers
      cs[1] = 1'b1; addr[1] = 16'hDEAD; wdat[1] = 16'h0BAD; we[1] = 1'b1; s_ack = 1'b0;
      for (int k = 0; k < TO + 1; k++) step();
      cs[1] = 1'b0;
      step();
      cs[0] = 1'b1; cs[1] = 1'b1; s_ack = 1'b1; s_dat = 16'h3333;
      step();
      cs[0] = 1'b0; cs[1] = 1'b0; s_ack = 1'b0;
      step();

      // abort by m1, then a stray ack, then contention
      cs[1] = 1'b1; addr[1] = 16'h0042; we[1] = 1'b0;
      step();
      step();
      cs[1] = 1'b0;
      step();
      s_ack = 1'b1; s_dat = 16'h9999;
      step();
      cs[0] = 1'b1; cs[1] = 1'b1;
      step();
      cs[0] = 1'b0; cs[1] = 1'b0; s_ack = 1'b0;
      step();

      // asynchronous reset in the middle of a BUSY transfer
      cs[0] = 1'b1; addr[0] = 16'h0F00; s_ack = 1'b0;
      step();
      step();
      apply();
      #2;
      i_reset_n = 1'b0;
      #1;
      chk("rst_s_cs",   32'(bus.o_s_cs),   32'd0);
      chk("rst_busy",   32'(bus.o_busy),   32'd0);
      chk("rst_m0_ack", 32'(bus.o_m0_ack), 32'd0);
      chk("rst_m1_ack", 32'(bus.o_m1_ack), 32'd0);
      chk("rst_owner",  32'(bus.o_owner),  32'd0);
      model_reset();
      @(posedge i_clk);
      cyc++;
      @(negedge i_clk);
      cs[0] = 1'b1; cs[1] = 1'b1;
      step();
      i_reset_n = 1'b1;
      s_ack = 1'b1; s_dat = 16'h1357;
      order_q.delete();
      step();
      chk("post_rst_winner", 32'(order_q.size() > 0 ? order_q[0] : 9), 32'd0);
      cs[0] = 1'b0; cs[1] = 1'b0; s_ack = 1'b0;
      step();

      // randomized traffic
      for (int k = 0; k < 1500; k++) begin
         randomize_inputs();
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dcpu_bus_arb.md
Name: dcpu_bus_arb

Overview:
- Two-master, one-slave arbiter for the dcpu memory bus (addr/dat/we/cs/ack).
- Master 0 is the dcpu core. Master 1 is a second requester, such as a debug loader or DMA engine.
- Arbitration is round-robin; once a master holds the bus, the grant stays with it until the slave acks or the request is aborted.
- A watchdog terminates transfers the slave never acks, so a missing or hung slave cannot stall the CPU forever.
- Sits between the core and the memory/peripheral decode.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- TIMEOUT, 255, cycles in BUSY without ack before forced termination; legal range 1..2^TW-1.
- TW, 8, watchdog counter width.
- ERR_DATA, 16'hFFFF, read data returned on a timed-out transfer.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_m0_addr  in  AW  master 0 address.
- i_m0_dat  in  DW  master 0 write data.
- i_m0_we  in  1  master 0 write enable.
- i_m0_cs  in  1  master 0 request; held until ack.
- o_m0_dat  out  DW  master 0 read data.
- o_m0_ack  out  1  master 0 transfer-complete strobe.
- o_m0_err  out  1  master 0 timeout flag; valid with ack.
- i_m1_addr, i_m1_dat, i_m1_we, i_m1_cs, o_m1_dat, o_m1_ack, o_m1_err: same as the m0 set, for master 1.
- o_s_addr  out  AW  slave address.
- o_s_dat  out  DW  slave write data.
- o_s_we  out  1  slave write enable.
- o_s_cs  out  1  slave select.
- i_s_dat  in  DW  slave read data.
- i_s_ack  in  1  slave ack.
- o_owner  out  1  current or last granted master.
- o_busy  out  1  high in BUSY state.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, r_prio=0 (master 0 preferred), watchdog=0, o_owner=0.
  - o_busy=0; all ack/err/cs/we outputs 0; all data/addr outputs 0.
- State register: IDLE, BUSY.
- IDLE, combinational grant:
  - Only m0 requesting: grant m0. Only m1 requesting: grant m1.
  - Both requesting: grant the master selected by r_prio.
  - The granted master's addr/dat/we/cs drive the slave port in the same cycle (zero added latency).
  - Grant + i_s_ack in the same cycle: single-cycle transfer. Ack goes to the winner, state stays IDLE.
  - Grant without ack: next state BUSY, owner latched into o_owner, watchdog cleared.
- BUSY:
  - Slave port is driven only from o_owner's signals; the other master's requests are ignored and its ack stays 0.
  - Watchdog increments each cycle without i_s_ack.
  - Owner cs drops (abort): o_s_cs=0 that cycle, no ack to anyone, next state IDLE.
  - i_s_ack with owner cs high: ack to owner, next state IDLE.
  - Watchdog==TIMEOUT-1 with no ack: owner gets ack=1, err=1, dat=ERR_DATA; o_s_cs=0 that cycle; next state IDLE.
- Round-robin: on every completed transfer (ack or timeout), r_prio becomes ~winner. An abort leaves r_prio unchanged.
- Ack routing:
  - i_s_ack is forwarded only to the granted master.
  - o_mX_dat = i_s_dat when X is granted, else 0.
  - i_s_ack while no master is granted is ignored.
- o_mX_err is 0 except in the single timeout cycle.
- Slave outputs are all 0 when no grant is active.
- Back-to-back: a master holding cs across its ack re-arbitrates in the next IDLE cycle. With both masters requesting continuously, grants strictly alternate.
- Reset asserted mid-transfer: immediate IDLE, all outputs return to reset values; the in-flight transfer is dropped without ack.

Test Plan:
- Single master: m0 reads 0x0010, slave acks in the same cycle with 0xBEEF → o_m0_ack=1 and o_m0_dat=0xBEEF that cycle; o_busy stays 0; o_m1_ack=0.
- Contention: m0 and m1 both raise cs from reset, slave acks after 2 cycles each → order m0, m1, m0, m1; o_owner toggles; no ack ever reaches the non-owner.
- Lock: m0 owns the bus with the slave delaying ack 5 cycles; m1 raises cs at cycle 1 → o_s_addr stays at m0's address until m0's ack; m1 is granted the following cycle.
- Timeout: TIMEOUT=4, m1 write to an address the slave never acks → o_m1_ack=1, o_m1_err=1, o_m1_dat=0xFFFF on the 4th cycle after grant, with o_s_cs=0 that cycle; r_prio then favours m0.
- Abort: m1 drops cs in BUSY → o_s_cs falls in the same cycle, no ack is generated, r_prio is unchanged; a later slave ack is ignored.
- Async reset: assert i_reset_n=0 between clock edges during BUSY → o_s_cs, o_busy and all acks go to 0 immediately; after release, m0 wins the first contention.
